// File: rtl/gpi_rx_pkg.sv
// Shared types and defaults for the GPI receive conditioner.
package gpi_rx_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEB_W_DEF       = 16;

    // state       | meaning
    // DISABLED    | receiver off, level held, no pulses
    // SETTLE      | pad just enabled, synchroniser flushing gated zeros
    // STABLE      | level valid, watching for a difference
    // QUALIFY     | difference seen, counting confirming cycles
    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_STABLE   = 2'd2,
        ST_QUALIFY  = 2'd3
    } gpi_rx_state_e;

    // Pad Schmitt-trigger select encodings.
    typedef enum logic [1:0] {
        STE_OFF  = 2'b00,
        STE_LOW  = 2'b01,
        STE_HIGH = 2'b10,
        STE_BOTH = 2'b11
    } gpi_rx_ste_e;

endpackage

// File: rtl/gpi_rx_sync.sv
// Multi-flop synchroniser; resets to 1 to match the pad pull-up idle level.
module gpi_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous pad bit through the flop chain.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain[STAGES-1];

endmodule

// File: rtl/gpi_rx_conditioner.sv
// GPI pad receive conditioner: synchronise, debounce, edge-detect.
// Optional sticky interrupt when GPI_RX_IRQ_EN is defined.
module gpi_rx_conditioner
    import gpi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_W       = DEB_W_DEF
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic [1:0]       ste_cfg_i,
    input  logic [DEB_W-1:0] deb_limit_i,
    output logic             pad_ie_o,
    output logic [1:0]       pad_ste_o,
    input  logic [1:0]       pad_di_i,
`ifdef GPI_RX_IRQ_EN
    input  logic             rise_ie_i,
    input  logic             fall_ie_i,
    input  logic             irq_clr_i,
    output logic             irq_o,
`endif
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o
);

    localparam int SW = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SYNC_STAGES);

    gpi_rx_state_e    state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic             level_d, rise_d, fall_d;
    logic             sync_di;
    logic             pad_di_unused;

    // Pad bit 1 carries nothing useful for this receiver.
    assign pad_di_unused = pad_di_i[1];

    gpi_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (pad_di_i[0]),
        .q_o    (sync_di)
    );

    // Pad control outputs, one cycle behind their configuration inputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pad_ie_o  <= 1'b0;
            pad_ste_o <= STE_OFF;
        end else begin
            pad_ie_o  <= en_i;
            pad_ste_o <= ste_cfg_i;
        end
    end

    // FSM state, counters and registered level/pulse outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_DISABLED;
            settle_q <= '0;
            deb_q    <= '0;
            level_o  <= 1'b1;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            deb_q    <= deb_d;
            level_o  <= level_d;
            rise_o   <= rise_d;
            fall_o   <= fall_d;
        end
    end

    // Next-state logic; disable overrides everything and drops any pending qualify.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        deb_d    = deb_q;
        level_d  = level_o;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (!en_i) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
                ST_SETTLE: begin
                    // Level is adopted silently once gated zeros have flushed.
                    if (settle_q >= SETTLE_LAST) begin
                        level_d = sync_di;
                        state_d = ST_STABLE;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (sync_di != level_o) begin
                        state_d = ST_QUALIFY;
                        deb_d   = '0;
                    end
                end
                ST_QUALIFY: begin
                    // >= so that lowering the limit mid-count accepts promptly.
                    if (sync_di == level_o) begin
                        state_d = ST_STABLE;
                    end else if (deb_q >= deb_limit_i) begin
                        level_d = sync_di;
                        rise_d  = sync_di;
                        fall_d  = !sync_di;
                        state_d = ST_STABLE;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

`ifdef GPI_RX_IRQ_EN
    // Sticky interrupt; a new enabled edge wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= (rise_o & rise_ie_i) | (fall_o & fall_ie_i) | (irq_o & ~irq_clr_i);
        end
    end
`endif

endmodule

// File: tb/tb_gpi_rx_conditioner.sv
// Directed testbench for gpi_rx_conditioner (SYNC_STAGES=2, DEB_W=16).
module tb_gpi_rx_conditioner;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [1:0]  ste_cfg;
    logic [15:0] deb_limit;
    logic        pad_ie;
    logic [1:0]  pad_ste;
    logic [1:0]  pad_di;
    logic        level;
    logic        rise;
    logic        fall;
`ifdef GPI_RX_IRQ_EN
    logic        rise_ie;
    logic        fall_ie;
    logic        irq_clr;
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    gpi_rx_conditioner #(
        .SYNC_STAGES (2),
        .DEB_W       (16)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .en_i        (en),
        .ste_cfg_i   (ste_cfg),
        .deb_limit_i (deb_limit),
        .pad_ie_o    (pad_ie),
        .pad_ste_o   (pad_ste),
        .pad_di_i    (pad_di),
`ifdef GPI_RX_IRQ_EN
        .rise_ie_i   (rise_ie),
        .fall_ie_i   (fall_ie),
        .irq_clr_i   (irq_clr),
        .irq_o       (irq),
`endif
        .level_o     (level),
        .rise_o      (rise),
        .fall_o      (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the pad and let the level follow with the shortest qualify.
    task automatic restore_level(input logic lvl);
        deb_limit = 16'd0;
        pad_di    = {1'b0, lvl};
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; ste_cfg = 2'b11; deb_limit = 16'd4; pad_di = 2'b01;
        repeat (2) tick();
        checks++; if (pad_ie !== 1'b0) begin errors++; $display("FAIL reset_ie: got %b expected 0", pad_ie); end
        checks++; if (pad_ste !== 2'b00) begin errors++; $display("FAIL reset_ste: got %b expected 00", pad_ste); end
        checks++; if (level !== 1'b1) begin errors++; $display("FAIL reset_level: got %b expected 1", level); end
        checks++; if (rise !== 1'b0 || fall !== 1'b0) begin errors++; $display("FAIL reset_pulses: got rise=%b fall=%b expected 0 0", rise, fall); end
        rstn = 1'b1;
        tick();
        checks++; if (pad_ste !== 2'b11) begin errors++; $display("FAIL ste_pass: got %b expected 11", pad_ste); end
        checks++; if (pad_ie !== 1'b0) begin errors++; $display("FAIL ie_while_disabled: got %b expected 0", pad_ie); end
    endtask

    task automatic test_enable_settle();
        en = 1'b1;
        tick();
        checks++; if (pad_ie !== 1'b1) begin errors++; $display("FAIL enable_ie: got %b expected 1", pad_ie); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (level !== 1'b1 || rise !== 1'b0 || fall !== 1'b0) begin
                errors++; $display("FAIL settle_idle[%0d]: got level=%b rise=%b fall=%b expected 1 0 0", i, level, rise, fall);
            end
        end
    endtask

    task automatic test_settle_loads_silently();
        en = 1'b0; pad_di = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (level !== 1'b1 || fall !== 1'b0) begin
                errors++; $display("FAIL disabled_hold[%0d]: got level=%b fall=%b expected 1 0", i, level, fall);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (level !== 1'b1) begin errors++; $display("FAIL settle_len[%0d]: got level=%b expected 1", i, level); end
        end
        tick();
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL settle_load: got level=%b expected 0", level); end
        checks++; if (fall !== 1'b0 || rise !== 1'b0) begin errors++; $display("FAIL settle_no_pulse: got rise=%b fall=%b expected 0 0", rise, fall); end
    endtask

    task automatic test_rise_min_limit();
        deb_limit = 16'd0; pad_di = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (level !== 1'b0 || rise !== 1'b0) begin
                errors++; $display("FAIL rise_early[%0d]: got level=%b rise=%b expected 0 0", i, level, rise);
            end
        end
        tick();
        checks++; if (level !== 1'b1 || rise !== 1'b1 || fall !== 1'b0) begin errors++; $display("FAIL rise_accept: got level=%b rise=%b fall=%b expected 1 1 0", level, rise, fall); end
        tick();
        checks++; if (rise !== 1'b0) begin errors++; $display("FAIL rise_single: got rise=%b expected 0", rise); end
    endtask

    task automatic test_fall();
        deb_limit = 16'd4; pad_di = 2'b00;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (level !== 1'b1 || fall !== 1'b0) begin
                errors++; $display("FAIL fall_early[%0d]: got level=%b fall=%b expected 1 0", i, level, fall);
            end
        end
        tick();
        checks++; if (level !== 1'b0 || fall !== 1'b1 || rise !== 1'b0) begin errors++; $display("FAIL fall_accept: got level=%b fall=%b rise=%b expected 0 1 0", level, fall, rise); end
        tick();
        checks++; if (fall !== 1'b0) begin errors++; $display("FAIL fall_single: got fall=%b expected 0", fall); end
    endtask

    task automatic test_glitch();
        deb_limit = 16'd4; pad_di = 2'b00;
        repeat (3) tick();
        pad_di = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (level !== 1'b1 || fall !== 1'b0) begin
                errors++; $display("FAIL glitch_reject[%0d]: got level=%b fall=%b expected 1 0", i, level, fall);
            end
        end
    endtask

    task automatic test_limit_lowered();
        deb_limit = 16'd15; pad_di = 2'b00;
        repeat (8) tick();
        checks++; if (level !== 1'b1) begin errors++; $display("FAIL lower_before: got level=%b expected 1", level); end
        deb_limit = 16'd2;
        tick();
        checks++; if (level !== 1'b0 || fall !== 1'b1) begin errors++; $display("FAIL lower_accept: got level=%b fall=%b expected 0 1", level, fall); end
        tick();
    endtask

    task automatic test_disable_mid_qualify();
        deb_limit = 16'd4; pad_di = 2'b01;
        repeat (4) tick();
        en = 1'b0;
        tick();
        checks++; if (pad_ie !== 1'b0) begin errors++; $display("FAIL disable_ie: got %b expected 0", pad_ie); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (level !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
                errors++; $display("FAIL disable_drop[%0d]: got level=%b rise=%b fall=%b expected 0 0 0", i, level, rise, fall);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (level !== 1'b0 || rise !== 1'b0) begin
                errors++; $display("FAIL reenable_settle[%0d]: got level=%b rise=%b expected 0 0", i, level, rise);
            end
        end
        tick();
        checks++; if (level !== 1'b1 || rise !== 1'b0) begin errors++; $display("FAIL reenable_load: got level=%b rise=%b expected 1 0", level, rise); end
    endtask

    task automatic test_reset_mid_qualify();
        restore_level(1'b0);
        deb_limit = 16'd4; pad_di = 2'b01;
        repeat (5) tick();
        rstn = 1'b0;
        #2;
        checks++; if (level !== 1'b1) begin errors++; $display("FAIL async_level: got %b expected 1", level); end
        checks++; if (pad_ie !== 1'b0 || pad_ste !== 2'b00) begin errors++; $display("FAIL async_pad: got ie=%b ste=%b expected 0 00", pad_ie, pad_ste); end
        checks++; if (rise !== 1'b0 || fall !== 1'b0) begin errors++; $display("FAIL async_pulses: got rise=%b fall=%b expected 0 0", rise, fall); end
        repeat (2) tick();
        rstn = 1'b1;
    endtask

`ifdef GPI_RX_IRQ_EN
    task automatic test_irq();
        rise_ie = 1'b1; fall_ie = 1'b0; irq_clr = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_reset: got %b expected 0", irq); end
        pad_di = 2'b01;
        repeat (6) tick();
        deb_limit = 16'd0; pad_di = 2'b00;
        repeat (5) tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall_masked: got %b expected 0", irq); end
        pad_di = 2'b01;
        repeat (4) tick();
        checks++; if (rise !== 1'b1) begin errors++; $display("FAIL irq_rise_seen: got %b expected 1", rise); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
        pad_di = 2'b00;
        repeat (6) tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_sticky: got %b expected 1", irq); end
        pad_di = 2'b01;
        repeat (4) tick();
        checks++; if (rise !== 1'b1) begin errors++; $display("FAIL irq_rise2_seen: got %b expected 1", rise); end
        irq_clr = 1'b1;
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
        irq_clr = 1'b0;
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_stays_clear: got %b expected 0", irq); end
    endtask
`endif

    initial begin
`ifdef GPI_RX_IRQ_EN
        rise_ie = 1'b0; fall_ie = 1'b0; irq_clr = 1'b0;
`endif
        test_reset();
        test_enable_settle();
        test_settle_loads_silently();
        test_rise_min_limit();
        test_fall();
        restore_level(1'b1);
        test_glitch();
        test_fall();
        restore_level(1'b1);
        test_limit_lowered();
        test_disable_mid_qualify();
        test_reset_mid_qualify();
`ifdef GPI_RX_IRQ_EN
        test_irq();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
